// File: rtl/morse_pkg.sv
// Shared Morse pattern definitions: 12-bit MSB-first patterns, the 8-letter table and decoder states.
package morse_pkg;

   localparam int MORSE_BITS    = 12;
   localparam int MORSE_LETTERS = 8;

   typedef logic [MORSE_BITS-1:0] morse_pattern_t;

   // 1 = key down for one unit; dots are "10", dashes "1110", padded with zeros
   localparam morse_pattern_t MORSE_TABLE [MORSE_LETTERS] = '{
      12'b101110000000,
      12'b111010101000,
      12'b111010111010,
      12'b111010100000,
      12'b100000000000,
      12'b101011101000,
      12'b111011101000,
      12'b101010100000
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      MATCH = 2'd2
   } decoder_state_t;

endpackage

// File: rtl/morse_lookup.sv
// Combinational table match: pattern in, {hit, index} out; lowest matching index wins.
module morse_lookup
   import morse_pkg::*;
(
   input  morse_pattern_t pattern,
   output logic           hit,
   output logic [2:0]     index
);

   always_comb begin
      hit   = 1'b0;
      index = 3'd0;
      // Walk downwards so the lowest matching entry is the one left standing
      for (int i = MORSE_LETTERS - 1; i >= 0; i--) begin
         if (pattern == MORSE_TABLE[i]) begin
            hit   = 1'b1;
            index = 3'(i);
         end
      end
   end

endmodule

// File: rtl/morse_bit_decoder.sv
// Morse bit decoder: captures 12 strobed bits, matches them against the letter table.
// Optional run-length symbol counters are built when MORSE_SYMBOL_COUNT_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for Start; strobes ignored
//  RECV  | shifting in bits, watching for a stalled stream
//  MATCH | one cycle: table compare, publish letter or flag error
module morse_bit_decoder
   import morse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       ClockIn,
   input  logic       ResetN,
   input  logic       Start,
   input  logic       DotDashIn,
   input  logic       NewBitIn,
   output logic [2:0] LetterOut,
   output logic       LetterValid,
   output logic       ErrorOut,
   output logic       Busy
`ifdef MORSE_SYMBOL_COUNT_EN
  ,output logic [2:0] DotCount,
   output logic [2:0] DashCount,
   output logic       SymbolErr
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_PRE  = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [3:0]    LAST_BIT     = 4'(MORSE_BITS - 1);

   decoder_state_t state;
   morse_pattern_t shift_reg;
   logic [3:0]     bit_cnt;
   logic [TW-1:0]  timeout_cnt;
   logic           lookup_hit;
   logic [2:0]     lookup_index;
   logic           bit_accept;

   morse_lookup u_lookup (
      .pattern (shift_reg),
      .hit     (lookup_hit),
      .index   (lookup_index)
   );

   assign bit_accept = (state == RECV) && NewBitIn && !Start;
   assign Busy       = (state != IDLE);

   always_ff @(posedge ClockIn or negedge ResetN) begin
      if (!ResetN) begin
         state       <= IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         timeout_cnt <= '0;
         LetterOut   <= '0;
         LetterValid <= 1'b0;
         ErrorOut    <= 1'b0;
      end else begin
         LetterValid <= 1'b0;
         if (Start) begin
            // Start overrides everything, including a strobe in the same cycle
            state       <= RECV;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            timeout_cnt <= '0;
            ErrorOut    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
               end
               RECV: begin
                  if (NewBitIn) begin
                     shift_reg   <= {shift_reg[MORSE_BITS-2:0], DotDashIn};
                     bit_cnt     <= bit_cnt + 4'd1;
                     timeout_cnt <= '0;
                     if (bit_cnt == LAST_BIT) begin
                        state <= MATCH;
                     end
                  end else if (timeout_cnt >= TIMEOUT_PRE) begin
                     timeout_cnt <= TIMEOUT_LAST;
                     ErrorOut    <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     timeout_cnt <= timeout_cnt + 1'b1;
                  end
               end
               MATCH: begin
                  if (lookup_hit) begin
                     LetterOut   <= lookup_index;
                     LetterValid <= 1'b1;
                  end else begin
                     ErrorOut <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef MORSE_SYMBOL_COUNT_EN
   logic [3:0] run_len;
   logic       run_close;

   // A run of 1s ends on an accepted 0, or is still open when MATCH is reached
   assign run_close = (run_len != 4'd0) &&
                      ((bit_accept && !DotDashIn) || (state == MATCH && !Start));

   always_ff @(posedge ClockIn or negedge ResetN) begin
      if (!ResetN) begin
         run_len   <= '0;
         DotCount  <= '0;
         DashCount <= '0;
         SymbolErr <= 1'b0;
      end else if (Start) begin
         run_len   <= '0;
         DotCount  <= '0;
         DashCount <= '0;
         SymbolErr <= 1'b0;
      end else if (run_close) begin
         run_len <= '0;
         if (run_len == 4'd1) begin
            DotCount <= DotCount + 3'd1;
         end else if (run_len == 4'd3) begin
            DashCount <= DashCount + 3'd1;
         end else begin
            SymbolErr <= 1'b1;
         end
      end else if (bit_accept && DotDashIn) begin
         run_len <= run_len + 4'd1;
      end
   end
`endif

endmodule

// File: tb/tb_morse_bit_decoder.sv
// Self-checking bench for morse_bit_decoder: table of letter vectors plus directed corner sequences.
module tb_morse_bit_decoder;

   localparam int TIMEOUT_CYCLES = 1024;

   logic       ClockIn;
   logic       ResetN;
   logic       Start;
   logic       DotDashIn;
   logic       NewBitIn;
   logic [2:0] LetterOut;
   logic       LetterValid;
   logic       ErrorOut;
   logic       Busy;
`ifdef MORSE_SYMBOL_COUNT_EN
   logic [2:0] DotCount;
   logic [2:0] DashCount;
   logic       SymbolErr;
`endif

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   morse_bit_decoder #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .ClockIn     (ClockIn),
      .ResetN      (ResetN),
      .Start       (Start),
      .DotDashIn   (DotDashIn),
      .NewBitIn    (NewBitIn),
      .LetterOut   (LetterOut),
      .LetterValid (LetterValid),
      .ErrorOut    (ErrorOut),
      .Busy        (Busy)
`ifdef MORSE_SYMBOL_COUNT_EN
     ,.DotCount    (DotCount),
      .DashCount   (DashCount),
      .SymbolErr   (SymbolErr)
`endif
   );

   initial ClockIn = 1'b0;
   always #5 ClockIn = ~ClockIn;

   always @(negedge ClockIn) if (LetterValid) pulses++;

   typedef struct {
      logic [11:0] pattern;
      logic [2:0]  exp_letter;
      logic        exp_err;
      int          exp_pulses;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic with_bit);
      Start     = 1'b1;
      NewBitIn  = with_bit;
      DotDashIn = 1'b1;
      @(posedge ClockIn); #1;
      Start    = 1'b0;
      NewBitIn = 1'b0;
   endtask

   // Returns just after the edge that captures the last bit
   task automatic send_bits(input logic [11:0] pat, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat (gap - 1) @(posedge ClockIn);
         #1;
         DotDashIn = pat[11-i];
         NewBitIn  = 1'b1;
         @(posedge ClockIn); #1;
         NewBitIn = 1'b0;
      end
   endtask

   initial begin
      int p0;
      vecs[0] = '{12'b101110000000, 3'd0, 1'b0, 1};
      vecs[1] = '{12'b111010101000, 3'd1, 1'b0, 1};
      vecs[2] = '{12'b111010111010, 3'd2, 1'b0, 1};
      vecs[3] = '{12'b111010100000, 3'd3, 1'b0, 1};
      vecs[4] = '{12'b100000000000, 3'd4, 1'b0, 1};
      vecs[5] = '{12'b101011101000, 3'd5, 1'b0, 1};
      vecs[6] = '{12'b111111111111, 3'd5, 1'b1, 0};
      vecs[7] = '{12'b111011101000, 3'd6, 1'b0, 1};
      vecs[8] = '{12'b101010100000, 3'd7, 1'b0, 1};
      vecs[9] = '{12'b000000000000, 3'd7, 1'b1, 0};

      ResetN = 1'b0; Start = 1'b0; DotDashIn = 1'b0; NewBitIn = 1'b0;
      #12;
      check("rst_letter", LetterOut, 0);
      check("rst_valid", LetterValid, 0);
      check("rst_error", ErrorOut, 0);
      check("rst_busy", Busy, 0);
      #10 ResetN = 1'b1;
      @(posedge ClockIn); #1;

      // Letter 2 at full bit spacing, exact latency
      pulse_start(1'b0);
      check("t1_busy_armed", Busy, 1);
      p0 = pulses;
      send_bits(12'b111010111010, 12, 251);
      check("t1_valid_match", LetterValid, 0);
      check("t1_busy_match", Busy, 1);
      @(posedge ClockIn); #1;
      check("t1_valid_t2", LetterValid, 1);
      check("t1_busy_t2", Busy, 0);
      check("t1_letter", LetterOut, 2);
      check("t1_error", ErrorOut, 0);
      @(posedge ClockIn); #1;
      check("t1_valid_t3", LetterValid, 0);
      check("t1_pulses", pulses - p0, 1);

      for (int v = 0; v < 10; v++) begin
         pulse_start(1'b0);
         p0 = pulses;
         send_bits(vecs[v].pattern, 12, 3);
         repeat (3) @(posedge ClockIn);
         #1;
         check($sformatf("vec%0d_letter", v), LetterOut, vecs[v].exp_letter);
         check($sformatf("vec%0d_error", v), ErrorOut, vecs[v].exp_err);
         check($sformatf("vec%0d_busy", v), Busy, 0);
         check($sformatf("vec%0d_pulses", v), pulses - p0, vecs[v].exp_pulses);
      end

      // Stalled stream
      pulse_start(1'b0);
      send_bits(12'b101110000000, 5, 3);
      repeat (TIMEOUT_CYCLES - 30) @(posedge ClockIn);
      #1;
      check("t3_busy_before", Busy, 1);
      check("t3_error_before", ErrorOut, 0);
      repeat (40) @(posedge ClockIn);
      #1;
      check("t3_error", ErrorOut, 1);
      check("t3_busy", Busy, 0);
      p0 = pulses;
      send_bits(12'b101110000000, 12, 3);
      repeat (3) @(posedge ClockIn);
      #1;
      check("t3_ignored_pulses", pulses - p0, 0);
      check("t3_ignored_busy", Busy, 0);
      check("t3_letter_kept", LetterOut, 7);

      // Restart mid-capture
      pulse_start(1'b0);
      send_bits(12'b101010100000, 6, 3);
      pulse_start(1'b0);
      check("t4_error_cleared", ErrorOut, 0);
      p0 = pulses;
      send_bits(12'b100000000000, 12, 3);
      repeat (3) @(posedge ClockIn);
      #1;
      check("t4_letter", LetterOut, 4);
      check("t4_error", ErrorOut, 0);
      check("t4_pulses", pulses - p0, 1);

      // Start with a coincident strobe: that bit must not enter the pattern
      pulse_start(1'b1);
      send_bits(12'b111011101000, 12, 3);
      repeat (3) @(posedge ClockIn);
      #1;
      check("t4_coincident_letter", LetterOut, 6);
      check("t4_coincident_error", ErrorOut, 0);

      // Asynchronous reset mid-capture
      pulse_start(1'b0);
      send_bits(12'b101110000000, 8, 3);
      #2 ResetN = 1'b0;
      #1;
      check("t5_letter", LetterOut, 0);
      check("t5_busy", Busy, 0);
      check("t5_error", ErrorOut, 0);
      check("t5_valid", LetterValid, 0);
      @(posedge ClockIn); #3;
      ResetN = 1'b1;
      @(posedge ClockIn); #1;
      p0 = pulses;
      send_bits(12'b000000000000, 4, 3);
      repeat (3) @(posedge ClockIn);
      #1;
      check("t5_no_pulse", pulses - p0, 0);
      check("t5_idle", Busy, 0);

`ifdef MORSE_SYMBOL_COUNT_EN
      pulse_start(1'b0);
      send_bits(12'b111010101000, 12, 3);
      @(posedge ClockIn); #1;
      check("t6_valid", LetterValid, 1);
      check("t6_dots", DotCount, 3);
      check("t6_dashes", DashCount, 1);
      check("t6_symerr", SymbolErr, 0);
      pulse_start(1'b0);
      send_bits(12'b111010111010, 12, 3);
      @(posedge ClockIn); #1;
      check("t6b_dots", DotCount, 2);
      check("t6b_dashes", DashCount, 2);
      check("t6b_symerr", SymbolErr, 0);
      pulse_start(1'b0);
      send_bits(12'b110000000000, 12, 3);
      @(posedge ClockIn); #1;
      check("t6c_symerr", SymbolErr, 1);
      check("t6c_error", ErrorOut, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
